// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus arbiter states
// and requester indices on the 8-bit bus.
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN,
    ARB_GAP
  } arb_state_e;

  localparam int REQ_RAX = 0;
  localparam int REQ_RBX = 1;
  localparam int REQ_RCX = 2;
  localparam int REQ_RDX = 3;
  localparam int REQ_ALU = 4;
  localparam int REQ_MEM = 5;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first request after last_ptr,
// scanning upward with wrap-around.
module rr_pick #(
  parameter int N_REQ = 6,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic [IW-1:0] p;

  // Scan last+1 .. last+N_REQ; first hit wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    p     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      p = IW'((int'(last_i) + k) % N_REQ);
      if (!any_o && req_i[p]) begin
        any_o    = 1'b1;
        gnt_o[p] = 1'b1;
        idx_o    = p;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with locked hold,
// hold timeout and optional turnaround gap.
module bus_arbiter
  import cpu_pkg::*;
#(
  parameter int N_REQ      = 6,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_id,
  output logic             timeout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST0 = IW'(N_REQ - 1);
  localparam bit TMO_EN = (MAX_HOLD > 1);
  localparam bit GAP_EN = (TURNAROUND != 0);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    last_q, last_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             tmo_q, tmo_d;

  logic [N_REQ-1:0] pk_gnt;
  logic [IW-1:0]    pk_idx;
  logic             pk_any;
  logic             keep;
  logic             others;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pk_gnt),
    .idx_o  (pk_idx),
    .any_o  (pk_any)
  );

  // Next state: hold, release to gap/new owner, or idle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    hold_d  = hold_q;
    tmo_d   = 1'b0;
    keep    = req[id_q] & lock[id_q];
    others  = |(req & ~grant_q);
    unique case (state_q)
      ARB_OWN: begin
        if (keep && hold_q < HMAX) begin
          hold_d = hold_q + 1'b1;
        end else begin
          tmo_d = keep & TMO_EN;
          if (others && GAP_EN) begin
            state_d = ARB_GAP;
            grant_d = '0;
            id_d    = '0;
          end else if (pk_any) begin
            grant_d = pk_gnt;
            id_d    = pk_idx;
            last_d  = pk_idx;
            hold_d  = '0;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
            id_d    = '0;
          end
        end
      end
      ARB_IDLE, ARB_GAP: begin
        if (pk_any) begin
          state_d = ARB_OWN;
          grant_d = pk_gnt;
          id_d    = pk_idx;
          last_d  = pk_idx;
          hold_d  = '0;
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
          id_d    = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  // State and output registers, async clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= LAST0;
      hold_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = id_q;
  assign timeout     = tmo_q;

endmodule
